// File: rtl/gpio_in_pkg.sv
// Shared defaults and width helpers for the GPIO input debounce path.
package gpio_in_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_TICK_DIV     = 1024;
  localparam int unsigned DEF_STABLE_TICKS = 16;
  localparam int unsigned DEF_SYNC_STAGES  = 2;

  // Bits needed to hold n_states distinct values, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n_states);
    return (n_states <= 2) ? 1 : $clog2(n_states);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser, stability counter, debounced level and edge pulses.
module gpio_debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_pin,
  input  logic i_tick,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = cnt_width(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Metastability chain from the asynchronous pad.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // Accept a new value only after it survives STABLE_TICKS ticks; any glitch restarts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CW'(STABLE_TICKS - 1)) begin
          r_level <= w_s;
          r_cnt   <= '0;
          r_rise  <= w_s;
          r_fall  <= ~w_s;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced GPIO inputs with edge pulses and a single-entry change-event register.
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_level,
  output logic [WIDTH-1:0] evt_mask,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int unsigned PW = cnt_width(TICK_DIV);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] w_chg;
  logic             w_accept;
  logic             w_ovf_set;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_level;
  logic [WIDTH-1:0] r_evt_mask;
  logic             r_ovf;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Shared sample-tick prescaler, 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_bit (
      .clk     (clk),
      .resetn  (resetn),
      .i_pin   (pins[g]),
      .i_tick  (w_tick),
      .o_level (level[g]),
      .o_rise  (rise[g]),
      .o_fall  (fall[g])
    );
  end

  assign w_chg     = rise | fall;
  assign w_accept  = r_evt_valid & evt_ready;
  assign w_ovf_set = (|w_chg) & r_evt_valid & ~evt_ready & (|(r_evt_mask & w_chg));

  // Event holding register: load when free or being read, otherwise merge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_evt_valid <= 1'b0;
      r_evt_level <= {WIDTH{RESET_LEVEL}};
      r_evt_mask  <= '0;
    end else if (w_chg == '0) begin
      if (w_accept) begin
        r_evt_valid <= 1'b0;
        r_evt_mask  <= '0;
      end
    end else if (!r_evt_valid || w_accept) begin
      r_evt_valid <= 1'b1;
      r_evt_level <= level;
      r_evt_mask  <= w_chg;
    end else begin
      r_evt_level <= level;
      r_evt_mask  <= r_evt_mask | w_chg;
    end
  end

  // Sticky overflow; a new set outranks a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_level = r_evt_level;
  assign evt_mask  = r_evt_mask;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: tick-counting reference model plus directed and random stimulus.
module tb_gpio_in_debounce;

  localparam int unsigned W    = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned ST   = 3;
  localparam int unsigned SS   = 2;
  localparam logic        RL   = 1'b0;
  localparam int          LOGN = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] pins;
  logic [W-1:0] level, rise, fall;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_level, evt_mask;
  logic         ovf;
  logic         ovf_clr;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  gpio_in_debounce #(
    .WIDTH        (W),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .SYNC_STAGES  (SS),
    .RESET_LEVEL  (RL)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pins      (pins),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_level (evt_level),
    .evt_mask  (evt_mask),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of sample ticks in edge range [a,b]; a tick lands on edge j when (j+1)%TD==0.
  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / TD - a / TD;
  endfunction

  // Reference model state
  int           m_k;
  logic [W-1:0] pin_log [LOGN];
  int           m_ds [W];
  logic [W-1:0] m_level, m_rise, m_fall, m_el, m_em;
  logic         m_ev, m_ovf;

  // Model: pin seen SS edges late; level flips when a run of difference spans ST ticks.
  always @(posedge clk or negedge resetn) begin : model
    logic [W-1:0] s, nl, nr, nf, chg, nem, nel;
    logic         nev, novf, setovf;
    int           nds [W];
    if (!resetn) begin
      m_k     <= 0;
      m_level <= {W{RL}};
      m_rise  <= '0;
      m_fall  <= '0;
      m_ev    <= 1'b0;
      m_el    <= {W{RL}};
      m_em    <= '0;
      m_ovf   <= 1'b0;
      for (int i = 0; i < W; i++) m_ds[i] <= -1;
    end else begin
      chg = m_rise | m_fall;
      nev = m_ev; nem = m_em; nel = m_el; setovf = 1'b0;
      if (chg == '0) begin
        if (m_ev && evt_ready) begin nev = 1'b0; nem = '0; end
      end else if (!m_ev || evt_ready) begin
        nev = 1'b1; nem = chg; nel = m_level;
      end else begin
        setovf = |(m_em & chg); nem = m_em | chg; nel = m_level;
      end
      novf = setovf ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      s = (m_k >= SS) ? pin_log[(m_k - SS) % LOGN] : {W{RL}};
      nl = m_level; nr = '0; nf = '0;
      for (int i = 0; i < W; i++) begin
        nds[i] = m_ds[i];
        if (s[i] == m_level[i]) begin
          nds[i] = -1;
        end else begin
          if (nds[i] < 0) nds[i] = m_k;
          if (ticks_in(nds[i], m_k) == ST) begin
            nl[i] = s[i]; nr[i] = s[i]; nf[i] = ~s[i]; nds[i] = -1;
          end
        end
      end
      pin_log[m_k % LOGN] <= pins;
      for (int i = 0; i < W; i++) m_ds[i] <= nds[i];
      m_level <= nl; m_rise <= nr; m_fall <= nf;
      m_ev <= nev; m_em <= nem; m_el <= nel; m_ovf <= novf;
      m_k <= m_k + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level), 32'(m_level));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("evt_valid", 32'(evt_valid), 32'(m_ev));
      chk("evt_level", 32'(evt_level), 32'(m_el));
      chk("evt_mask", 32'(evt_mask), 32'(m_em));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  function automatic int model_cnt(input int b);
    return (m_ds[b] < 0) ? 0 : ticks_in(m_ds[b], m_k - 1);
  endfunction

  initial begin : stim
    int   n;
    logic seen;
    resetn = 1'b0; pins = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Idle after reset
    repeat (100) @(negedge clk);
    chk("idle_level", 32'(level), 32'h0);
    chk("idle_edges", 32'(rise | fall), 32'h0);
    chk("idle_evt_valid", 32'(evt_valid), 32'h0);
    chk("idle_ovf", 32'(ovf), 32'h0);

    // Single rise on pin 0 with latency bounds
    pins[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[0] && n < 40);
    chk("p0_rise_seen", 32'(rise[0]), 32'h1);
    chk("p0_latency_in_range", 32'(n >= 11 && n <= 14), 32'h1);
    @(negedge clk);
    chk("p0_rise_one_cycle", 32'(rise[0]), 32'h0);
    chk("p0_evt_valid", 32'(evt_valid), 32'h1);
    chk("p0_evt_level", 32'(evt_level), 32'h1);
    chk("p0_evt_mask", 32'(evt_mask), 32'h1);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("p0_evt_read", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // Short pulses on pin 1 never qualify
    seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      pins[1] = 1'b1;
      repeat (6) begin @(negedge clk); seen |= rise[1] | fall[1]; end
      pins[1] = 1'b0;
      repeat (6) begin @(negedge clk); seen |= rise[1] | fall[1]; end
    end
    repeat (20) begin @(negedge clk); seen |= rise[1] | fall[1]; end
    chk("glitch_no_edge", 32'(seen), 32'h0);
    chk("glitch_level", 32'(level), 32'h1);
    chk("glitch_no_evt", 32'(evt_valid), 32'h0);

    // Merge without overlap, then overlap raises ovf
    pins[2] = 1'b1;
    repeat (20) @(negedge clk);
    pins[3] = 1'b1;
    repeat (20) @(negedge clk);
    chk("merge_mask", 32'(evt_mask), 32'hc);
    chk("merge_level", 32'(evt_level), 32'hd);
    chk("merge_no_ovf", 32'(ovf), 32'h0);
    pins[2] = 1'b0;
    repeat (20) @(negedge clk);
    chk("ovf_mask", 32'(evt_mask), 32'hc);
    chk("ovf_level", 32'(evt_level), 32'h9);
    chk("ovf_set", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'h0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;

    // Read and new change in the same cycle
    pins[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("pend_mask", 32'(evt_mask), 32'h1);
    pins[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[1] && n < 40);
    chk("p1_rise_seen", 32'(rise[1]), 32'h1);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("same_cycle_valid", 32'(evt_valid), 32'h1);
    chk("same_cycle_mask", 32'(evt_mask), 32'h2);
    @(negedge clk);
    chk("same_cycle_drain", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // Reset mid-qualification with an event pending
    pins[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!evt_valid && n < 40);
    chk("pre_rst_evt_valid", 32'(evt_valid), 32'h1);
    pins[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (model_cnt(2) != 2 && n < 40);
    chk("pre_rst_cnt2", 32'(model_cnt(2)), 32'h2);
    #2 resetn = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_edges", 32'(rise | fall), 32'h0);
    chk("rst_evt", 32'({evt_valid, evt_level, evt_mask}), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[2] && n < 40);
    chk("requal_rise", 32'(rise[2]), 32'h1);
    chk("requal_from_zero", 32'(n >= 11 && n <= 14), 32'h1);

    // Random traffic with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 15) == 0) pins[i] = ~pins[i];
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if (c == 1500) begin
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
